// File: rtl/inst_fetch_resp_pkg.sv
// Shared widths, constants, FSM encodings and IF/ID payload type for the
// instruction fetch responder.
package inst_fetch_resp_pkg;

    localparam int unsigned INST_ADDR_W = 32;   // instruction address bus width
    localparam int unsigned INST_W      = 32;   // instruction word width
    localparam int unsigned TIMER_W     = 8;    // bus watchdog width

    // Cycles a request may stay unacknowledged before a bus error.
    localparam int unsigned TIMEOUT_CYCLES = 255;
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    localparam logic [INST_W-1:0] ZERO_WORD   = '0;
    localparam logic              RST_ENABLE  = 1'b1;
    localparam logic              CHIP_ENABLE = 1'b1;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;   // ready for a fetch
    localparam logic [1:0] ST_WAIT  = 2'd1;   // request outstanding
    localparam logic [1:0] ST_HOLD  = 2'd2;   // word captured, downstream stalled
    localparam logic [1:0] ST_DRAIN = 2'd3;   // flushed request still on the bus

    // Payload presented to the IF/ID stage
    typedef struct packed {
        logic [INST_W-1:0]      inst;
        logic [INST_ADDR_W-1:0] pc;
        logic                   valid;
    } if_payload_t;

    // Word-aligned fetch address check
    function automatic logic is_aligned(input logic [INST_ADDR_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/inst_fetch_resp_line_buf.sv
// Module: ifr_line_buf
// One-entry last-fetch buffer: tag/data/valid register with hit compare.
// Ports:
//   i_clk, i_rst      clock, async active-high reset
//   i_fill            write (i_fill_tag, i_fill_data) and mark valid
//   i_inv             clear valid; wins over a same-cycle fill
//   i_lookup_tag      address compared against the stored tag
//   o_hit_c           combinational hit for i_lookup_tag
//   o_tag, o_data     stored tag and data
module ifr_line_buf
    import inst_fetch_resp_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_fill,
    input  logic                   i_inv,
    input  logic [INST_ADDR_W-1:0] i_fill_tag,
    input  logic [INST_W-1:0]      i_fill_data,
    input  logic [INST_ADDR_W-1:0] i_lookup_tag,
    output logic                   o_hit_c,
    output logic [INST_ADDR_W-1:0] o_tag,
    output logic [INST_W-1:0]      o_data
);

    logic                   r_valid;
    logic [INST_ADDR_W-1:0] r_tag;
    logic [INST_W-1:0]      r_data;

    // Tag/data are written on every fill, even when invalidated in the same
    // cycle, so a word parked in HOLD can still be presented from here.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst == RST_ENABLE) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= ZERO_WORD;
        end else begin
            if (i_fill) begin
                r_tag  <= i_fill_tag;
                r_data <= i_fill_data;
            end
            if (i_inv) begin
                r_valid <= 1'b0;
            end else if (i_fill) begin
                r_valid <= 1'b1;
            end
        end
    end

    assign o_hit_c = r_valid && (r_tag == i_lookup_tag);
    assign o_tag   = r_tag;
    assign o_data  = r_data;

endmodule

// File: rtl/inst_fetch_resp.sv
// Module: inst_fetch_resp
// Memory-side fetch responder: serves PC fetches from a one-entry buffer or
// a variable-latency req/ack memory, with stall, flush and bus timeout.
// Ports:
//   clk, rst                     clock, async active-high reset
//   pc_i, ce_i                   fetch address / chip enable from PC stage
//   stall_i, flush_i, inv_i      downstream stall, flush, buffer invalidate
//   inst_o, inst_pc_o, inst_valid_o   IF/ID payload
//   busy_o                       miss outstanding, PC must hold
//   misalign_o, buserr_o         1-cycle error pulses
//   mem_req_o, mem_addr_o        memory request (held until ack)
//   mem_ack_i, mem_rdata_i       memory completion pulse and data
module inst_fetch_resp
    import inst_fetch_resp_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INST_ADDR_W-1:0] pc_i,
    input  logic                   ce_i,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic                   inv_i,
    output logic [INST_W-1:0]      inst_o,
    output logic [INST_ADDR_W-1:0] inst_pc_o,
    output logic                   inst_valid_o,
    output logic                   busy_o,
    output logic                   misalign_o,
    output logic                   buserr_o,
    output logic                   mem_req_o,
    output logic [INST_ADDR_W-1:0] mem_addr_o,
    input  logic                   mem_ack_i,
    input  logic [INST_W-1:0]      mem_rdata_i
);

    logic [1:0]             r_state,    w_state_nx;
    if_payload_t            r_fetch,    w_fetch_nx;
    logic                   r_busy,     w_busy_nx;
    logic                   r_misalign, w_misalign_nx;
    logic                   r_buserr,   w_buserr_nx;
    logic                   r_mem_req,  w_mem_req_nx;
    logic [INST_ADDR_W-1:0] r_mem_addr, w_mem_addr_nx;
    logic [TIMER_W-1:0]     r_timer,    w_timer_nx;

    logic                   w_fill;
    logic                   w_hit_c;
    logic [INST_ADDR_W-1:0] w_buf_tag;
    logic [INST_W-1:0]      w_buf_data;
    logic [TIMER_W-1:0]     w_timer_inc;
    logic                   w_timeout;

    ifr_line_buf u_line_buf (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_fill       (w_fill),
        .i_inv        (inv_i),
        .i_fill_tag   (r_mem_addr),
        .i_fill_data  (mem_rdata_i),
        .i_lookup_tag (pc_i),
        .o_hit_c      (w_hit_c),
        .o_tag        (w_buf_tag),
        .o_data       (w_buf_data)
    );

    // Saturating watchdog increment and expiry on the last allowed cycle
    assign w_timer_inc = (r_timer == '1) ? r_timer : r_timer + TIMER_W'(1);
    assign w_timeout   = (r_timer == TIMEOUT_LAST);

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            r_state    <= ST_IDLE;
            r_fetch    <= '0;
            r_busy     <= 1'b0;
            r_misalign <= 1'b0;
            r_buserr   <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_timer    <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_fetch    <= w_fetch_nx;
            r_busy     <= w_busy_nx;
            r_misalign <= w_misalign_nx;
            r_buserr   <= w_buserr_nx;
            r_mem_req  <= w_mem_req_nx;
            r_mem_addr <= w_mem_addr_nx;
            r_timer    <= w_timer_nx;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nx    = r_state;
        w_fetch_nx    = r_fetch;
        w_busy_nx     = r_busy;
        w_misalign_nx = 1'b0;
        w_buserr_nx   = 1'b0;
        w_mem_req_nx  = r_mem_req;
        w_mem_addr_nx = r_mem_addr;
        w_timer_nx    = r_timer;
        w_fill        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (flush_i) begin
                    w_fetch_nx.inst  = ZERO_WORD;
                    w_fetch_nx.valid = 1'b0;
                end else if (stall_i) begin
                    // hold the presented word
                end else if (ce_i != CHIP_ENABLE) begin
                    w_fetch_nx.inst  = ZERO_WORD;
                    w_fetch_nx.valid = 1'b0;
                end else if (!is_aligned(pc_i)) begin
                    w_fetch_nx.inst  = ZERO_WORD;
                    w_fetch_nx.pc    = pc_i;
                    w_fetch_nx.valid = 1'b1;
                    w_misalign_nx    = 1'b1;
                end else if (w_hit_c) begin
                    w_fetch_nx.inst  = w_buf_data;
                    w_fetch_nx.pc    = pc_i;
                    w_fetch_nx.valid = 1'b1;
                end else begin
                    w_fetch_nx.inst  = ZERO_WORD;
                    w_fetch_nx.valid = 1'b0;
                    w_mem_req_nx     = 1'b1;
                    w_mem_addr_nx    = pc_i;
                    w_busy_nx        = 1'b1;
                    w_timer_nx       = '0;
                    w_state_nx       = ST_WAIT;
                end
            end

            ST_WAIT: begin
                w_timer_nx = w_timer_inc;
                if (mem_ack_i) begin
                    w_fill       = 1'b1;
                    w_mem_req_nx = 1'b0;
                    if (flush_i) begin
                        w_fetch_nx.inst  = ZERO_WORD;
                        w_fetch_nx.valid = 1'b0;
                        w_busy_nx        = 1'b0;
                        w_state_nx       = ST_IDLE;
                    end else if (stall_i) begin
                        w_state_nx = ST_HOLD;
                    end else begin
                        w_fetch_nx.inst  = mem_rdata_i;
                        w_fetch_nx.pc    = r_mem_addr;
                        w_fetch_nx.valid = 1'b1;
                        w_busy_nx        = 1'b0;
                        w_state_nx       = ST_IDLE;
                    end
                end else if (w_timeout) begin
                    w_mem_req_nx     = 1'b0;
                    w_buserr_nx      = 1'b1;
                    w_fetch_nx.inst  = ZERO_WORD;
                    w_fetch_nx.pc    = r_mem_addr;
                    w_fetch_nx.valid = 1'b1;
                    w_busy_nx        = 1'b0;
                    w_state_nx       = ST_IDLE;
                end else if (flush_i) begin
                    // Request cannot be withdrawn; let it drain silently
                    w_fetch_nx.inst  = ZERO_WORD;
                    w_fetch_nx.valid = 1'b0;
                    w_timer_nx       = '0;
                    w_state_nx       = ST_DRAIN;
                end
            end

            ST_HOLD: begin
                // Captured word lives in the line buffer until release
                if (flush_i) begin
                    w_fetch_nx.inst  = ZERO_WORD;
                    w_fetch_nx.valid = 1'b0;
                    w_busy_nx        = 1'b0;
                    w_state_nx       = ST_IDLE;
                end else if (!stall_i) begin
                    w_fetch_nx.inst  = w_buf_data;
                    w_fetch_nx.pc    = w_buf_tag;
                    w_fetch_nx.valid = 1'b1;
                    w_busy_nx        = 1'b0;
                    w_state_nx       = ST_IDLE;
                end
            end

            ST_DRAIN: begin
                w_timer_nx = w_timer_inc;
                if (mem_ack_i) begin
                    w_fill       = 1'b1;
                    w_mem_req_nx = 1'b0;
                    w_busy_nx    = 1'b0;
                    w_state_nx   = ST_IDLE;
                end else if (w_timeout) begin
                    w_mem_req_nx = 1'b0;
                    w_buserr_nx  = 1'b1;
                    w_busy_nx    = 1'b0;
                    w_state_nx   = ST_IDLE;
                end
            end

            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    assign inst_o       = r_fetch.inst;
    assign inst_pc_o    = r_fetch.pc;
    assign inst_valid_o = r_fetch.valid;
    assign busy_o       = r_busy;
    assign misalign_o   = r_misalign;
    assign buserr_o     = r_buserr;
    assign mem_req_o    = r_mem_req;
    assign mem_addr_o   = r_mem_addr;

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Testbench for inst_fetch_resp: per-cycle vector table plus hand-written
// sequences for bus timeout and asynchronous reset mid-fetch.
module tb_inst_fetch_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        ce_i, stall_i, flush_i, inv_i;
    logic [31:0] inst_o, inst_pc_o;
    logic        inst_valid_o, busy_o, misalign_o, buserr_o, mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    inst_fetch_resp dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .ce_i         (ce_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .inv_i        (inv_i),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_valid_o (inst_valid_o),
        .busy_o       (busy_o),
        .misalign_o   (misalign_o),
        .buserr_o     (buserr_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] ipc;
        logic [4:0]  flags;   // {valid, busy, misalign, buserr, mem_req}
        logic [31:0] addr;
    } out_t;

    typedef struct packed {
        logic [5:0]  ctl;     // {rst, ce, stall, flush, inv, ack}
        logic [31:0] pc;
        logic [31:0] rdata;
        out_t        exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [5:0] ctl, input logic [31:0] pc, input logic [31:0] rdata,
                       input logic [31:0] inst, input logic [31:0] ipc, input logic [4:0] flags,
                       input logic [31:0] addr);
        vec_t v;
        v.ctl = ctl; v.pc = pc; v.rdata = rdata;
        v.exp.inst = inst; v.exp.ipc = ipc; v.exp.flags = flags; v.exp.addr = addr;
        vecs.push_back(v);
    endtask

    function automatic out_t sample();
        out_t o;
        o.inst  = inst_o;
        o.ipc   = inst_pc_o;
        o.flags = {inst_valid_o, busy_o, misalign_o, buserr_o, mem_req_o};
        o.addr  = mem_addr_o;
        return o;
    endfunction

    task automatic chk_out(input string name, input out_t act, input out_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got inst=%h pc=%h v/b/m/e/r=%b addr=%h, want inst=%h pc=%h v/b/m/e/r=%b addr=%h",
                      name, act.inst, act.ipc, act.flags, act.addr, exp.inst, exp.ipc, exp.flags, exp.addr);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    initial begin
        int req_cycles;
        bit seen_err;

        rst = 1'b1; pc_i = '0; ce_i = 0; stall_i = 0; flush_i = 0; inv_i = 0;
        mem_ack_i = 0; mem_rdata_i = '0;

        //    rcsfia     pc           rdata          inst           ipc        vbmer     addr
        add(6'b100000, 32'h000, 32'h0,        32'h0,        32'h000, 5'b00000, 32'h000); // reset
        add(6'b010000, 32'h100, 32'h0,        32'h0,        32'h000, 5'b01001, 32'h100); // miss
        add(6'b010000, 32'h100, 32'h0,        32'h0,        32'h000, 5'b01001, 32'h100);
        add(6'b010000, 32'h100, 32'h0,        32'h0,        32'h000, 5'b01001, 32'h100);
        add(6'b010001, 32'h100, 32'h2401000A, 32'h2401000A, 32'h100, 5'b10000, 32'h100); // ack
        add(6'b010000, 32'h100, 32'h0,        32'h2401000A, 32'h100, 5'b10000, 32'h100); // hit
        add(6'b010010, 32'h100, 32'h0,        32'h2401000A, 32'h100, 5'b10000, 32'h100); // hit + inv
        add(6'b010000, 32'h100, 32'h0,        32'h0,        32'h100, 5'b01001, 32'h100); // miss after inv
        add(6'b010001, 32'h100, 32'h2401000A, 32'h2401000A, 32'h100, 5'b10000, 32'h100);
        add(6'b010000, 32'h102, 32'h0,        32'h0,        32'h102, 5'b10100, 32'h100); // misalign
        add(6'b000000, 32'h102, 32'h0,        32'h0,        32'h102, 5'b00000, 32'h100); // ce=0
        add(6'b010000, 32'h200, 32'h0,        32'h0,        32'h102, 5'b01001, 32'h200); // miss
        add(6'b011001, 32'h200, 32'h3C011234, 32'h0,        32'h102, 5'b01000, 32'h200); // ack under stall
        add(6'b011000, 32'h200, 32'h0,        32'h0,        32'h102, 5'b01000, 32'h200);
        add(6'b011000, 32'h200, 32'h0,        32'h0,        32'h102, 5'b01000, 32'h200);
        add(6'b011000, 32'h200, 32'h0,        32'h0,        32'h102, 5'b01000, 32'h200);
        add(6'b010000, 32'h200, 32'h0,        32'h3C011234, 32'h200, 5'b10000, 32'h200); // release
        add(6'b010000, 32'h300, 32'h0,        32'h0,        32'h200, 5'b01001, 32'h300); // miss
        add(6'b010100, 32'h300, 32'h0,        32'h0,        32'h200, 5'b01001, 32'h300); // flush -> DRAIN
        add(6'b000000, 32'h300, 32'h0,        32'h0,        32'h200, 5'b01001, 32'h300);
        add(6'b000001, 32'h300, 32'hAAAA5555, 32'h0,        32'h200, 5'b00000, 32'h300); // drained ack
        add(6'b010000, 32'h300, 32'h0,        32'hAAAA5555, 32'h300, 5'b10000, 32'h300); // hit on drained fill
        add(6'b010100, 32'h300, 32'h0,        32'h0,        32'h300, 5'b00000, 32'h300); // flush in IDLE
        add(6'b010000, 32'h300, 32'h0,        32'hAAAA5555, 32'h300, 5'b10000, 32'h300);
        add(6'b011000, 32'h400, 32'h0,        32'hAAAA5555, 32'h300, 5'b10000, 32'h300); // stall holds
        add(6'b000000, 32'h400, 32'h0,        32'h0,        32'h300, 5'b00000, 32'h300);
        add(6'b010000, 32'h500, 32'h0,        32'h0,        32'h300, 5'b01001, 32'h500); // miss
        add(6'b010011, 32'h500, 32'h11112222, 32'h11112222, 32'h500, 5'b10000, 32'h500); // ack + inv
        add(6'b010000, 32'h500, 32'h0,        32'h0,        32'h500, 5'b01001, 32'h500); // inv won: miss
        add(6'b010001, 32'h500, 32'h11112222, 32'h11112222, 32'h500, 5'b10000, 32'h500);
        add(6'b010000, 32'h600, 32'h0,        32'h0,        32'h500, 5'b01001, 32'h600); // miss
        add(6'b011001, 32'h600, 32'h66666666, 32'h0,        32'h500, 5'b01000, 32'h600); // -> HOLD
        add(6'b011100, 32'h600, 32'h0,        32'h0,        32'h500, 5'b00000, 32'h600); // flush in HOLD
        add(6'b010000, 32'h600, 32'h0,        32'h66666666, 32'h600, 5'b10000, 32'h600); // buffer kept
        add(6'b000000, 32'h600, 32'h0,        32'h0,        32'h600, 5'b00000, 32'h600);

        @(negedge clk);
        foreach (vecs[i]) begin
            {rst, ce_i, stall_i, flush_i, inv_i, mem_ack_i} = vecs[i].ctl;
            pc_i        = vecs[i].pc;
            mem_rdata_i = vecs[i].rdata;
            @(posedge clk); #1;
            chk_out($sformatf("row%0d", i), sample(), vecs[i].exp);
            @(negedge clk);
        end

        // Bus timeout: request held 255 cycles, then buserr pulse
        {rst, ce_i, stall_i, flush_i, inv_i, mem_ack_i} = 6'b010000;
        pc_i = 32'h700; mem_rdata_i = '0;
        @(posedge clk); #1;
        chk("to_issue_req", {31'd0, mem_req_o}, 32'd1);
        ce_i = 1'b0;
        req_cycles = 1;
        seen_err = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (buserr_o) begin seen_err = 1; break; end
            if (mem_req_o) req_cycles++;
        end
        chk("to_seen", {31'd0, seen_err}, 32'd1);
        chk("to_req_cycles", req_cycles, 32'd255);
        chk_out("to_err_outputs", sample(), '{inst: 32'h0, ipc: 32'h700, flags: 5'b10010, addr: 32'h700});
        @(posedge clk); #1;
        chk_out("to_after_pulse", sample(), '{inst: 32'h0, ipc: 32'h700, flags: 5'b00000, addr: 32'h700});

        // Asynchronous reset mid-WAIT, late ack ignored
        @(negedge clk);
        ce_i = 1'b1; pc_i = 32'h800;
        @(posedge clk); #1;
        chk("rst_pre_req", {31'd0, mem_req_o}, 32'd1);
        ce_i = 1'b0;
        #2 rst = 1'b1;
        #1 chk_out("rst_immediate", sample(), '0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        @(posedge clk); #1;
        chk_out("rst_late_ack", sample(), '0);
        @(negedge clk);
        mem_ack_i = 1'b0; ce_i = 1'b1; pc_i = 32'h800;
        @(posedge clk); #1;
        chk_out("rst_refetch_miss", sample(), '{inst: 32'h0, ipc: 32'h0, flags: 5'b01001, addr: 32'h800});
        @(negedge clk);
        ce_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h12345678;
        @(posedge clk); #1;
        chk_out("rst_refetch_data", sample(), '{inst: 32'h12345678, ipc: 32'h800, flags: 5'b10000, addr: 32'h800});
        @(negedge clk);
        mem_ack_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
